dvid_tx: RTL and testbench

//  DVI-D transmitter core: TMDS-encodes (8b/10b, DVI 1.0) one 3-bit-per-colour VGA pixel stream

---
 rtl/dvid_tx.sv | 168 ++++++++++++++++
 tb/tb_dvid_tx.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvid_tx.sv
`default_nettype none
// ============================================================================
//  Module   : dvid_tx
//  Purpose  : DVI-D transmitter core. TMDS 8b/10b encodes a 3-bit-per-colour
//             pixel stream into three data channels plus one clock channel.
//             Each 10-bit symbol is serialized as 2-bit pairs, LSB pair first,
//             for downstream DDR output cells. Runs on the 5x pixel clock.
//  Revision : 1.0  initial release
// ============================================================================
module dvid_tx #(
  parameter logic [9:0] CLK_SYMBOL = 10'b0000011111
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] red,
  input  logic [2:0] green,
  input  logic [2:0] blue,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       blank,
  output logic       pixel_strobe,
  output logic [1:0] out_ch0,
  output logic [1:0] out_ch1,
  output logic [1:0] out_ch2,
  output logic [1:0] out_ch3
);

  // Control tokens, indexed by {C1,C0}
  localparam logic [9:0] c_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] c_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] c_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] c_CTRL_11 = 10'b1010101011;

  // TMDS encoder for one channel. Returns {next_disparity[4:0], symbol[9:0]}.
  function automatic logic [14:0] tmds_encode(
    input logic [7:0]        d,
    input logic [1:0]        ctrl,
    input logic              is_blank,
    input logic signed [4:0] cnt
  );
    logic [8:0]        qm;
    logic [3:0]        n1d;
    logic [3:0]        n1q;
    logic              use_xnor;
    logic signed [4:0] diff;
    logic [9:0]        q;
    logic signed [4:0] cnt_n;

    n1d = 4'd0;
    for (int i = 0; i < 8; i++) n1d = n1d + {3'b000, d[i]};
    // Choose XNOR chaining when the byte is ones-heavy to minimise transitions
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);

    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~use_xnor;

    n1q = 4'd0;
    for (int i = 0; i < 8; i++) n1q = n1q + {3'b000, qm[i]};
    // ones minus zeros of q_m[7:0] = 2*n1 - 8, range -8..8
    diff = $signed({n1q, 1'b0}) - 5'sd8;

    if (is_blank) begin
      cnt_n = 5'sd0;
      case (ctrl)
        2'b00:   q = c_CTRL_00;
        2'b01:   q = c_CTRL_01;
        2'b10:   q = c_CTRL_10;
        default: q = c_CTRL_11;
      endcase
    end else if ((cnt == 5'sd0) || (diff == 5'sd0)) begin
      q     = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      cnt_n = qm[8] ? (cnt + diff) : (cnt - diff);
    end else if (((cnt > 5'sd0) && (diff > 5'sd0)) || ((cnt < 5'sd0) && (diff < 5'sd0))) begin
      q     = {1'b1, qm[8], ~qm[7:0]};
      cnt_n = cnt + (qm[8] ? 5'sd2 : 5'sd0) - diff;
    end else begin
      q     = {1'b0, qm[8], qm[7:0]};
      cnt_n = cnt - (qm[8] ? 5'sd0 : 5'sd2) + diff;
    end

    return {cnt_n, q};
  endfunction

  logic [2:0] r_phase;
  logic       r_strobe;
  logic       w_load;
  logic [7:0] w_data [3];
  logic [1:0] w_ctrl [3];
  logic [9:0] r_shift3;
  logic [1:0] r_out3;

  assign w_load = (r_phase == 3'd0);

  // Pixel phase counter 0..4; strobe is registered so it is high while phase==4
  always_ff @(posedge clock) begin
    if (reset) begin
      r_phase  <= 3'd0;
      r_strobe <= 1'b0;
    end else begin
      r_phase  <= (r_phase == 3'd4) ? 3'd0 : (r_phase + 3'd1);
      r_strobe <= (r_phase == 3'd3);
    end
  end

  // Expand 3-bit colours to 8 bits and route control bits per channel
  always_comb begin
    w_data[0] = {blue,  blue,  blue[2:1]};
    w_data[1] = {green, green, green[2:1]};
    w_data[2] = {red,   red,   red[2:1]};
    w_ctrl[0] = {vsync, hsync};
    w_ctrl[1] = 2'b00;
    w_ctrl[2] = 2'b00;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      logic [14:0]       w_enc;
      logic [9:0]        r_sym;
      logic [9:0]        r_shift;
      logic signed [4:0] r_cnt;
      logic [1:0]        r_out;

      // Encode the live inputs against this channel's running disparity
      always_comb w_enc = tmds_encode(w_data[gi], w_ctrl[gi], blank, r_cnt);

      // Capture/encode at phase 0, hand the previous symbol to the serializer
      always_ff @(posedge clock) begin
        if (reset) begin
          r_sym   <= c_CTRL_00;
          r_shift <= c_CTRL_00;
          r_cnt   <= 5'sd0;
          r_out   <= 2'b00;
        end else begin
          r_out <= r_shift[1:0];
          if (w_load) begin
            r_sym   <= w_enc[9:0];
            r_cnt   <= w_enc[14:10];
            r_shift <= r_sym;
          end else begin
            r_shift <= {2'b00, r_shift[9:2]};
          end
        end
      end
    end
  endgenerate

  // Clock channel: the same fixed symbol every pixel, serialized like the data
  always_ff @(posedge clock) begin
    if (reset) begin
      r_shift3 <= CLK_SYMBOL;
      r_out3   <= 2'b00;
    end else begin
      r_out3 <= r_shift3[1:0];
      if (w_load) r_shift3 <= CLK_SYMBOL;
      else        r_shift3 <= {2'b00, r_shift3[9:2]};
    end
  end

  assign pixel_strobe = r_strobe;
  assign out_ch0      = g_chan[0].r_out;
  assign out_ch1      = g_chan[1].r_out;
  assign out_ch2      = g_chan[2].r_out;
  assign out_ch3      = r_out3;

endmodule
`default_nettype wire

// File: tb/tb_dvid_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dvid_tx
//  Purpose  : Directed self-checking bench for dvid_tx. A background
//             deserializer rebuilds each 10-bit symbol from the bit pairs,
//             aligned on pixel_strobe, and logs it against the pixel sample.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dvid_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] red   = 3'd0;
  logic [2:0] green = 3'd0;
  logic [2:0] blue  = 3'd0;
  logic       hsync = 1'b0;
  logic       vsync = 1'b0;
  logic       blank = 1'b1;
  logic       pixel_strobe;
  logic [1:0] out_ch0, out_ch1, out_ch2, out_ch3;

  int checks   = 0;
  int failures = 0;

  localparam logic [9:0] c_CLK = 10'b0000011111;

  always #5 clock = ~clock;

  dvid_tx dut (
    .clock       (clock),
    .reset       (reset),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .hsync       (hsync),
    .vsync       (vsync),
    .blank       (blank),
    .pixel_strobe(pixel_strobe),
    .out_ch0     (out_ch0),
    .out_ch1     (out_ch1),
    .out_ch2     (out_ch2),
    .out_ch3     (out_ch3)
  );

  // Deserializer: pair p2 shows while strobe is high, p4 two cycles later
  logic [9:0] hist [4];
  logic [9:0] sym_log [4][512];
  int         cs = 100;
  int         sample_idx = 0;

  initial begin
    for (int c = 0; c < 4; c++) hist[c] = '0;
    forever begin
      @(posedge clock);
      #1;
      hist[0] = {out_ch0, hist[0][9:2]};
      hist[1] = {out_ch1, hist[1][9:2]};
      hist[2] = {out_ch2, hist[2][9:2]};
      hist[3] = {out_ch3, hist[3][9:2]};
      if (pixel_strobe === 1'b1) cs = 0;
      else if (cs < 100) cs++;
      if (cs == 2) begin
        sample_idx++;
        if (sample_idx >= 2 && sample_idx < 514)
          for (int c = 0; c < 4; c++) sym_log[c][sample_idx-2] = hist[c];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Present one pixel so that it is captured at the next phase-0 edge
  task automatic send_px(input logic [2:0] r, input logic [2:0] g, input logic [2:0] b,
                         input logic h, input logic v, input logic bl, output int idx);
    int n = 0;
    while (pixel_strobe !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    checks++;
    if (pixel_strobe !== 1'b1) begin
      failures++;
      $display("FAIL send_px_strobe got=%b want=1", pixel_strobe);
    end
    red = r; green = g; blue = b; hsync = h; vsync = v; blank = bl;
    tick();
    tick();
    idx = sample_idx;
  endtask

  task automatic wait_sym(input int idx, output logic [9:0] s0, output logic [9:0] s1,
                          output logic [9:0] s2, output logic [9:0] s3);
    int n = 0;
    while (sample_idx < idx + 2 && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (sample_idx < idx + 2) begin
      failures++;
      $display("FAIL wait_sym_timeout got=%0d want>=%0d", sample_idx, idx + 2);
    end
    s0 = sym_log[0][idx]; s1 = sym_log[1][idx]; s2 = sym_log[2][idx]; s3 = sym_log[3][idx];
  endtask

  // Reset values, strobe cadence after release, first ch0 pairs
  task automatic test_reset();
    logic [1:0] exp_ch0 [6];
    exp_ch0 = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b11};
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({out_ch3, out_ch2, out_ch1, out_ch0} !== 8'h00) begin
        failures++;
        $display("FAIL reset_outputs got=%h want=00", {out_ch3, out_ch2, out_ch1, out_ch0});
      end
      checks++;
      if (pixel_strobe !== 1'b0) begin
        failures++;
        $display("FAIL reset_strobe got=%b want=0", pixel_strobe);
      end
    end
    reset = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      checks++;
      if (pixel_strobe !== ((k % 5) == 4)) begin
        failures++;
        $display("FAIL strobe_cadence k=%0d got=%b want=%b", k, pixel_strobe, (k % 5) == 4);
      end
      if (k <= 6) begin
        checks++;
        if (out_ch0 !== exp_ch0[k-1]) begin
          failures++;
          $display("FAIL reset_ch0_pair k=%0d got=%b want=%b", k, out_ch0, exp_ch0[k-1]);
        end
      end
    end
  endtask

  // Clock channel pair pattern aligned to the strobe
  task automatic test_clock_channel();
    logic [1:0] exp_p [5];
    int n = 0;
    exp_p = '{2'b01, 2'b00, 2'b00, 2'b11, 2'b11};
    while (pixel_strobe !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (out_ch3 !== exp_p[j % 5]) begin
        failures++;
        $display("FAIL clock_channel j=%0d got=%b want=%b", j, out_ch3, exp_p[j % 5]);
      end
      tick();
    end
  endtask

  // Control tokens with colour inputs set, which must be ignored
  task automatic test_control();
    int a, b, c;
    logic [9:0] s0, s1, s2, s3;
    send_px(3'b111, 3'b101, 3'b011, 1'b1, 1'b0, 1'b1, a);
    send_px(3'b111, 3'b101, 3'b011, 1'b0, 1'b1, 1'b1, b);
    send_px(3'b111, 3'b101, 3'b011, 1'b1, 1'b1, 1'b1, c);
    wait_sym(a, s0, s1, s2, s3);
    checks++; if (s0 !== 10'b0010101011) begin failures++; $display("FAIL ctrl_h_ch0 got=%b want=0010101011", s0); end
    checks++; if (s1 !== 10'b1101010100) begin failures++; $display("FAIL ctrl_ch1 got=%b want=1101010100", s1); end
    checks++; if (s2 !== 10'b1101010100) begin failures++; $display("FAIL ctrl_ch2 got=%b want=1101010100", s2); end
    checks++; if (s3 !== c_CLK)          begin failures++; $display("FAIL ctrl_ch3 got=%b want=%b", s3, c_CLK); end
    wait_sym(b, s0, s1, s2, s3);
    checks++; if (s0 !== 10'b0101010100) begin failures++; $display("FAIL ctrl_v_ch0 got=%b want=0101010100", s0); end
    wait_sym(c, s0, s1, s2, s3);
    checks++; if (s0 !== 10'b1010101011) begin failures++; $display("FAIL ctrl_hv_ch0 got=%b want=1010101011", s0); end
  endtask

  // red=000 three pixels from cnt=0: cnt -8, then 2, then -6
  task automatic test_red_disparity();
    int i0, i1, i2, i3;
    logic [9:0] s0, s1, s2, s3;
    send_px(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, i0);
    send_px(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, i1);
    send_px(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, i2);
    send_px(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, i3);
    wait_sym(i1, s0, s1, s2, s3);
    checks++; if (s2 !== 10'b0100000000) begin failures++; $display("FAIL red_px1 got=%b want=0100000000", s2); end
    wait_sym(i2, s0, s1, s2, s3);
    checks++; if (s2 !== 10'b1111111111) begin failures++; $display("FAIL red_px2 got=%b want=1111111111", s2); end
    wait_sym(i3, s0, s1, s2, s3);
    checks++; if (s2 !== 10'b0100000000) begin failures++; $display("FAIL red_px3 got=%b want=0100000000", s2); end
  endtask

  // green=111 from cnt=0, blank clears cnt, then two more greens
  task automatic test_green_blank();
    int i0, i1, i2, i3, i4;
    logic [9:0] s0, s1, s2, s3;
    send_px(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, i0);
    send_px(3'b000, 3'b111, 3'b000, 1'b0, 1'b0, 1'b0, i1);
    send_px(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, i2);
    send_px(3'b000, 3'b111, 3'b000, 1'b0, 1'b0, 1'b0, i3);
    send_px(3'b000, 3'b111, 3'b000, 1'b0, 1'b0, 1'b0, i4);
    wait_sym(i1, s0, s1, s2, s3);
    checks++; if (s1 !== 10'b1000000000) begin failures++; $display("FAIL green_px1 got=%b want=1000000000", s1); end
    wait_sym(i2, s0, s1, s2, s3);
    checks++; if (s1 !== 10'b1101010100) begin failures++; $display("FAIL green_blank got=%b want=1101010100", s1); end
    wait_sym(i3, s0, s1, s2, s3);
    checks++; if (s1 !== 10'b1000000000) begin failures++; $display("FAIL green_after_blank got=%b want=1000000000", s1); end
    wait_sym(i4, s0, s1, s2, s3);
    checks++; if (s1 !== 10'b0011111111) begin failures++; $display("FAIL green_neg_cnt got=%b want=0011111111", s1); end
  endtask

  // Mid-range colours, including balanced q_m (n1==n0) on red and green
  task automatic test_mixed();
    int i0, i1, i2;
    logic [9:0] s0, s1, s2, s3;
    send_px(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, i0);
    send_px(3'b100, 3'b011, 3'b101, 1'b0, 1'b0, 1'b0, i1);
    send_px(3'b100, 3'b011, 3'b101, 1'b0, 1'b0, 1'b0, i2);
    wait_sym(i1, s0, s1, s2, s3);
    checks++; if (s2 !== 10'b0110001110) begin failures++; $display("FAIL mixed1_ch2 got=%b want=0110001110", s2); end
    checks++; if (s1 !== 10'b1010001110) begin failures++; $display("FAIL mixed1_ch1 got=%b want=1010001110", s1); end
    checks++; if (s0 !== 10'b1011000111) begin failures++; $display("FAIL mixed1_ch0 got=%b want=1011000111", s0); end
    wait_sym(i2, s0, s1, s2, s3);
    checks++; if (s2 !== 10'b0110001110) begin failures++; $display("FAIL mixed2_ch2 got=%b want=0110001110", s2); end
    checks++; if (s1 !== 10'b1010001110) begin failures++; $display("FAIL mixed2_ch1 got=%b want=1010001110", s1); end
    checks++; if (s0 !== 10'b0000111000) begin failures++; $display("FAIL mixed2_ch0 got=%b want=0000111000", s0); end
  endtask

  // Back-to-back blue pixels with junk driven between sample edges
  task automatic test_back_to_back();
    int idx [4];
    logic [9:0] s0, s1, s2, s3;
    logic [9:0] exp_b [3];
    exp_b = '{10'b1011000111, 10'b0000111000, 10'b1011000111};
    send_px(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, idx[0]);
    for (int p = 1; p < 4; p++) begin
      send_px(3'b000, 3'b000, 3'b101, 1'b0, 1'b0, 1'b0, idx[p]);
      tick();
      blue = 3'b010; blank = 1'b1; hsync = 1'b1; red = 3'b111;
    end
    for (int p = 1; p < 4; p++) begin
      wait_sym(idx[p], s0, s1, s2, s3);
      checks++;
      if (s0 !== exp_b[p-1]) begin
        failures++;
        $display("FAIL b2b_ch0 p=%0d got=%b want=%b", p, s0, exp_b[p-1]);
      end
    end
  endtask

  // Reset asserted mid-symbol while sending data
  task automatic test_reset_mid();
    logic [1:0] exp_ch0 [6];
    int i0;
    exp_ch0 = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b11};
    send_px(3'b110, 3'b001, 3'b011, 1'b0, 1'b0, 1'b0, i0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({out_ch3, out_ch2, out_ch1, out_ch0} !== 8'h00) begin
      failures++;
      $display("FAIL midreset_outputs got=%h want=00", {out_ch3, out_ch2, out_ch1, out_ch0});
    end
    checks++;
    if (pixel_strobe !== 1'b0) begin
      failures++;
      $display("FAIL midreset_strobe got=%b want=0", pixel_strobe);
    end
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (pixel_strobe !== (k == 4)) begin
        failures++;
        $display("FAIL midreset_phase k=%0d got=%b want=%b", k, pixel_strobe, k == 4);
      end
      checks++;
      if (out_ch0 !== exp_ch0[k-1]) begin
        failures++;
        $display("FAIL midreset_ch0 k=%0d got=%b want=%b", k, out_ch0, exp_ch0[k-1]);
      end
      if (k == 1 || k == 4) begin
        checks++;
        if (out_ch3 !== ((k == 1) ? 2'b11 : 2'b01)) begin
          failures++;
          $display("FAIL midreset_ch3 k=%0d got=%b want=%b", k, out_ch3, (k == 1) ? 2'b11 : 2'b01);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clock_channel();
    test_control();
    test_red_disparity();
    test_green_blank();
    test_mixed();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
